// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative set-on-compare unit: op encoding,
// FSM state type and the flag derivation rule.
package cmp_pkg;

  typedef logic [2:0] op_t;

  localparam op_t CMP_SLTU = 3'd0;
  localparam op_t CMP_SLT  = 3'd1;
  localparam op_t CMP_SGEU = 3'd2;
  localparam op_t CMP_SGE  = 3'd3;
  localparam op_t CMP_SEQ  = 3'd4;
  localparam op_t CMP_SNE  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Final flag from the deciding slice; reserved ops always yield 0.
  function automatic logic cmp_flag(op_t op, logic lt, logic eq);
    logic f;
    f = 1'b0;
    case (op)
      CMP_SLTU, CMP_SLT: f = lt;
      CMP_SGEU, CMP_SGE: f = ~lt;
      CMP_SEQ:           f = eq;
      CMP_SNE:           f = ~eq;
      default:           f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cmp_iter_if.sv
// Start/busy/done handshake bundle between the control unit (master) and
// the compare unit (slave).
interface cmp_iter_if
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             flag;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, flag, result);
  modport slave  (input start, op, a, b, output busy, done, flag, result);
endinterface

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one CHUNK-bit operand slice.
module cmp_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt_c,
  output logic             gt_c
);
  assign lt_c = (a < b);
  assign gt_c = (a > b);
endmodule

// File: rtl/cmp_iter.sv
// Multi-cycle set-on-compare unit: MSB-first slice compare with early exit.
// Optional feature macro: CMP_SIGNED_EN (signed SLT/SGE via MSB inversion).
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic       clk,
  input  logic       rst,
  cmp_iter_if.slave  bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  a_in, b_in;
  op_t               op_q;
  logic [IDXW-1:0]   idx;
  logic [CHUNK-1:0]  sa, sb;
  logic              s_lt, s_gt;
  logic              diff, valid_op, finish;
  logic              busy_q, done_q, flag_q;
  logic              busy_d, done_d, flag_d;

  // Operand conditioning at acceptance
  always_comb begin
    a_in = bus.a;
    b_in = bus.b;
`ifdef CMP_SIGNED_EN
    if (bus.op == CMP_SLT || bus.op == CMP_SGE) begin
      a_in[WIDTH-1] = ~bus.a[WIDTH-1];
      b_in[WIDTH-1] = ~bus.b[WIDTH-1];
    end
`endif
  end

  assign sa = CHUNK'(a_q >> (CHUNK * idx));
  assign sb = CHUNK'(b_q >> (CHUNK * idx));

  cmp_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (sa),
    .b    (sb),
    .lt_c (s_lt),
    .gt_c (s_gt)
  );

  assign diff     = s_lt | s_gt;
  // Reserved ops never exit early so they always take full latency
  assign valid_op = (op_q <= CMP_SNE);
  assign finish   = (idx == '0) || (valid_op && diff);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      state  <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      flag_q <= flag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; flag only updates on RUN->DONE
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    flag_d = flag_q;
    if (state == RUN && finish) flag_d = cmp_flag(op_q, s_lt, ~diff);
  end

  // Operand/index datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= CMP_SLTU;
      idx  <= '0;
    end else if (state == IDLE && bus.start) begin
      a_q  <= a_in;
      b_q  <= b_in;
      op_q <= bus.op;
      idx  <= IDXW'(NCHUNK - 1);
    end else if (state == RUN && !finish) begin
      idx  <= idx - IDXW'(1);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.flag   = flag_q;
  assign bus.result = {{(WIDTH-1){1'b0}}, flag_q};

endmodule

// File: tb/tb_cmp_iter.sv
// Scoreboard bench for cmp_iter: driver pushes expected flag and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_cmp_iter;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
`ifdef CMP_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_iter_if #(.WIDTH(WIDTH)) cif ();
  cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .rst(rst), .bus(cif));

  typedef struct {
    logic flag;
    int   cyc;
    int   op;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer/signed compare of whole operands
  function automatic logic model_flag(input int op, input logic [15:0] a, input logic [15:0] b);
    logic lt;
    lt = (SIGNED_EN && (op == 1 || op == 3)) ? ($signed(a) < $signed(b)) : (a < b);
    case (op)
      0, 1:    return lt;
      2, 3:    return !lt;
      4:       return a == b;
      5:       return a != b;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles from acceptance to done: first differing nibble from the top decides
  function automatic int model_lat(input int op, input logic [15:0] a, input logic [15:0] b);
    int x;
    if (op > 5) return NCHUNK + 1;
    x = int'(a ^ b);
    for (int k = 1; k <= NCHUNK; k++)
      if (((x >> (CHUNK * (NCHUNK - k))) % (1 << CHUNK)) != 0) return k + 1;
    return NCHUNK + 1;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (cif.done === 1'b1) begin
      ndone++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no pending op (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check($sformatf("flag_op%0d", e.op), 32'(cif.flag), 32'(e.flag));
        check($sformatf("result_op%0d", e.op), 32'(cif.result), 32'(e.flag));
        check($sformatf("done_cycle_op%0d", e.op), 32'(cyc), 32'(e.cyc));
        check("busy_in_done", 32'(cif.busy), 32'd1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.flag = model_flag(op, a, b);
    e.cyc  = cyc + model_lat(op, a, b);
    e.op   = op;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic s, input int op, input logic [15:0] a, input logic [15:0] b);
    cif.start = s;
    cif.op    = 3'(op);
    cif.a     = a;
    cif.b     = b;
  endtask

  task automatic wait_done();
    int n0;
    n0 = ndone;
    for (int i = 0; i < 20 && ndone == n0; i++) step();
    if (ndone == n0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 20 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run_op(input int op, input logic [15:0] a, input logic [15:0] b);
    push_exp(op, a, b);
    drive(1'b1, op, a, b);
    step();
    cif.start = 1'b0;
    check("busy_after_accept", 32'(cif.busy), 32'd1);
    wait_done();
    step();
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          rop;
    rst = 1'b1;
    drive(1'b0, 0, 16'h0, 16'h0);
    repeat (3) step();
    check("reset_busy", 32'(cif.busy), 32'd0);
    check("reset_done", 32'(cif.done), 32'd0);
    check("reset_flag", 32'(cif.flag), 32'd0);
    check("reset_result", 32'(cif.result), 32'd0);
    rst = 1'b0;
    step();

    run_op(0, 16'h0003, 16'h0005);
    run_op(1, 16'h8000, 16'h0001);
    run_op(0, 16'h8000, 16'h0001);
    run_op(3, 16'h8000, 16'h0001);
    run_op(5, 16'h1234, 16'h1234);
    run_op(2, 16'h1234, 16'h1234);
    run_op(6, 16'h0001, 16'hF000);
    run_op(7, 16'h5555, 16'h5555);

    // Second start while busy must be ignored
    push_exp(0, 16'h00F0, 16'h0F00);
    drive(1'b1, 0, 16'h00F0, 16'h0F00);
    step();
    drive(1'b1, 0, 16'hFFFF, 16'h0000);
    step();
    cif.start = 1'b0;
    wait_done();
    step();

    // Leave flag=1, then reset mid-RUN: outputs clear and no done follows
    run_op(4, 16'h1234, 16'h1234);
    drive(1'b1, 4, 16'hABCD, 16'hABCD);
    step();
    cif.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("midrun_reset_busy", 32'(cif.busy), 32'd0);
    check("midrun_reset_done", 32'(cif.done), 32'd0);
    check("midrun_reset_flag", 32'(cif.flag), 32'd0);
    rst = 1'b0;
    repeat (8) step();
    run_op(5, 16'h0F00, 16'h0F01);

    // Random back-to-back ops, half with shared upper bits to vary latency
    for (int i = 0; i < 60; i++) begin
      rop = int'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (ra ^ 16'($urandom_range(0, 255) >> $urandom_range(0, 7)));
      run_op(rop, ra, rb);
    end

    repeat (5) step();
    check("queue_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
